// File: rtl/dsp_pkg.sv
// Shared OPMODE encodings and FSM state type for the DSP48A1 MAC sequencer.
package dsp_pkg;

    localparam int OPM_X_LSB = 0;
    localparam int OPM_Z_LSB = 2;
    localparam int OPM_FIELD_W = 2;

    localparam logic [1:0] OPM_X_ZERO = 2'b00;
    localparam logic [1:0] OPM_X_M    = 2'b01;
    localparam logic [1:0] OPM_Z_ZERO = 2'b00;
    localparam logic [1:0] OPM_Z_P    = 2'b10;

    function automatic logic [7:0] opm_code(input logic [1:0] z, input logic [1:0] x);
        logic [7:0] code;
        code = 8'h00;
        code[OPM_X_LSB +: OPM_FIELD_W] = x;
        code[OPM_Z_LSB +: OPM_FIELD_W] = z;
        return code;
    endfunction

    localparam logic [7:0] OPM_FIRST = opm_code(OPM_Z_ZERO, OPM_X_M);
    localparam logic [7:0] OPM_ACC   = opm_code(OPM_Z_P, OPM_X_M);
    localparam logic [7:0] OPM_HOLD  = opm_code(OPM_Z_P, OPM_X_ZERO);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/dsp_opmode_pipe.sv
// Register pipe that delays the issued OPMODE so it meets M at the slice post-adder.
module dsp_opmode_pipe
    import dsp_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] stage [DEPTH];

    // Reset loads HOLD so beats in flight cannot touch P afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= OPM_HOLD;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streaming dot-product controller driving a DSP48A1 slice as a P = P + A*B accumulator.
module dsp_mac_sequencer
    import dsp_pkg::*;
#(
    parameter int A_W     = 18,
    parameter int B_W     = 18,
    parameter int P_W     = 48,
    parameter int LEN_W   = 16,
    parameter int LAT     = 3,
    parameter int OPM_DLY = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [A_W-1:0]   s_a,
    input  logic [B_W-1:0]   s_b,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [P_W-1:0]   m_data,
    output logic [LEN_W-1:0] m_count,
    output logic [A_W-1:0]   dsp_a,
    output logic [B_W-1:0]   dsp_b,
    output logic [7:0]       dsp_opmode,
    input  logic [P_W-1:0]   dsp_p
);

    localparam int FCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    // Handshakes: a transfer happens in any cycle where valid && ready are both
    // high at the rising edge; ready never depends on valid on either channel.

    state_t             state;
    state_t             state_nxt;
    logic               take;
    logic [7:0]         opm_issue;
    logic [LEN_W-1:0]   count;
    logic [FCNT_W-1:0]  fcnt;
    logic               flush_done;

    assign dsp_a      = s_a;
    assign dsp_b      = s_b;
    assign s_ready    = (state == ST_IDLE) || (state == ST_ACCUM);
    assign take       = s_valid && s_ready;
    assign flush_done = (state == ST_FLUSH) && (fcnt == '0);

    // First beat of a vector uses Z = 0 so stale P never leaks into a result.
    always_comb begin
        opm_issue = OPM_HOLD;
        if (take) begin
            opm_issue = (state == ST_IDLE) ? OPM_FIRST : OPM_ACC;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    state_nxt = s_last ? ST_FLUSH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (take && s_last) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fcnt == '0) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_valid && m_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat counter saturates; accumulation in the slice carries on regardless.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (take) begin
            if (state == ST_IDLE) begin
                count <= LEN_W'(1);
            end else if (count != {LEN_W{1'b1}}) begin
                count <= count + LEN_W'(1);
            end
        end
    end

    // Flush counter covers the slice latency from the last beat to a settled P.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fcnt <= '0;
        end else if (take && s_last) begin
            fcnt <= FCNT_W'(LAT - 1);
        end else if ((state == ST_FLUSH) && (fcnt != '0)) begin
            fcnt <= fcnt - FCNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
        end else if (flush_done) begin
            m_valid <= 1'b1;
            m_data  <= dsp_p;
            m_count <= count;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    dsp_opmode_pipe #(
        .DEPTH(OPM_DLY)
    ) u_opm_pipe (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (opm_issue),
        .dout  (dsp_opmode)
    );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer wired to a behavioural DSP48A1 slice (A1/B1/M/P/OPMODE regs).
module tb_dsp_mac_sequencer;
    localparam int A_W     = 18;
    localparam int B_W     = 18;
    localparam int P_W     = 48;
    localparam int LEN_W   = 4;
    localparam int LAT     = 3;
    localparam int OPM_DLY = 1;

    logic              CLK     = 1'b0;
    logic              RST_N   = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_last  = 1'b0;
    logic              m_ready = 1'b1;
    logic [A_W-1:0]    s_a     = '0;
    logic [B_W-1:0]    s_b     = '0;
    logic              s_ready;
    logic              m_valid;
    logic [P_W-1:0]    m_data;
    logic [LEN_W-1:0]  m_count;
    logic [A_W-1:0]    dsp_a;
    logic [B_W-1:0]    dsp_b;
    logic [7:0]        dsp_opmode;
    logic [P_W-1:0]    dsp_p;

    always #5 CLK = ~CLK;

    dsp_mac_sequencer #(
        .A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W), .LAT(LAT), .OPM_DLY(OPM_DLY)
    ) dut (
        .CLK(CLK), .RST_N(RST_N),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_p(dsp_p)
    );

    // Slice model: A1/B1 -> M -> P, OPMODE registered once, never reset by the sequencer.
    logic signed [17:0] a1_reg  = '0;
    logic signed [17:0] b1_reg  = '0;
    logic signed [35:0] m_reg   = '0;
    logic [7:0]         opm_reg = 8'h08;
    logic [47:0]        p_reg   = '0;
    logic [47:0]        post_x;
    logic [47:0]        post_z;

    always_comb begin
        post_x = (opm_reg[1:0] == 2'b01) ? {{12{m_reg[35]}}, m_reg} : 48'd0;
        post_z = (opm_reg[3:2] == 2'b10) ? p_reg : 48'd0;
    end

    always @(posedge CLK) begin
        a1_reg  <= dsp_a;
        b1_reg  <= dsp_b;
        m_reg   <= a1_reg * b1_reg;
        opm_reg <= dsp_opmode;
        p_reg   <= post_z + post_x;
    end
    assign dsp_p = p_reg;

    // Scoreboard
    int               checks = 0;
    int               errors = 0;
    logic [P_W-1:0]   exp_q[$];
    logic [LEN_W-1:0] exp_cnt_q[$];
    logic signed [17:0] va [32];
    logic signed [17:0] vb [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [P_W-1:0] model_sum(input int n);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s += longint'(va[i]) * longint'(vb[i]);
        end
        return s[P_W-1:0];
    endfunction

    // Driver: one vector with `gap` bubbles between beats and `stall` cycles of m_ready low.
    task automatic send_vec(input int n, input int gap, input int stall,
                            output logic [P_W-1:0] got_d, output logic [LEN_W-1:0] got_c);
        logic [P_W-1:0]   ed;
        logic [LEN_W-1:0] ec;
        int               waits;
        exp_q.push_back(model_sum(n));
        exp_cnt_q.push_back((n > 15) ? LEN_W'(15) : LEN_W'(n));
        m_ready = (stall == 0);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_a     = va[i];
            s_b     = vb[i];
            s_last  = (i == n - 1);
            chk("s_ready_beat", 64'(s_ready), 64'd1);
            @(posedge CLK); #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i != n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    s_a = 18'($urandom);
                    s_b = 18'($urandom);
                    @(posedge CLK); #1;
                end
            end
        end
        waits = 0;
        while (!m_valid && waits < 40) begin
            @(posedge CLK); #1;
            waits++;
        end
        chk("latency", 64'(waits), 64'(LAT));
        got_d = m_data;
        got_c = m_count;
        ed = exp_q.pop_front();
        ec = exp_cnt_q.pop_front();
        chk("data_model", 64'(m_data), 64'(ed));
        chk("count_model", 64'(m_count), 64'(ec));
        for (int k = 0; k < stall; k++) begin
            @(posedge CLK); #1;
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_data", 64'(m_data), 64'(got_d));
            chk("stall_sready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        @(posedge CLK); #1;
        chk("release_valid", 64'(m_valid), 64'd0);
        chk("release_sready", 64'(s_ready), 64'd1);
    endtask

    typedef struct packed {
        logic [4:0]        n;
        logic [1:0]        gap;
        logic [3:0]        stall;
        logic [2:0][17:0]  a;
        logic [2:0][17:0]  b;
        logic [47:0]       exp_data;
        logic [3:0]        exp_count;
    } row_t;

    function automatic row_t mk_row(input int n, input int gap, input int stall,
                                    input int a0, input int a1, input int a2,
                                    input int b0, input int b1, input int b2,
                                    input logic [47:0] ed, input int ec);
        row_t r;
        r           = '0;
        r.n         = 5'(n);
        r.gap       = 2'(gap);
        r.stall     = 4'(stall);
        r.a[0]      = 18'(a0);
        r.a[1]      = 18'(a1);
        r.a[2]      = 18'(a2);
        r.b[0]      = 18'(b0);
        r.b[1]      = 18'(b1);
        r.b[2]      = 18'(b2);
        r.exp_data  = ed;
        r.exp_count = 4'(ec);
        return r;
    endfunction

    row_t tbl [7];

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [P_W-1:0]   d;
        logic [LEN_W-1:0] c;

        tbl[0] = mk_row(3, 0, 0, 2, 3, 4, 5, 6, 7, 48'd56, 3);
        tbl[1] = mk_row(3, 2, 0, 2, 3, 4, 5, 6, 7, 48'd56, 3);
        tbl[2] = mk_row(1, 0, 0, -3, 0, 0, 7, 0, 0, 48'hFFFF_FFFF_FFEB, 1);
        tbl[3] = mk_row(3, 0, 5, 2, 3, 4, 5, 6, 7, 48'd56, 3);
        tbl[4] = mk_row(1, 0, 0, 1, 0, 0, 1, 0, 0, 48'd1, 1);
        tbl[5] = mk_row(1, 0, 0, -131072, 0, 0, -131072, 0, 0, 48'h0004_0000_0000, 1);
        tbl[6] = mk_row(2, 1, 0, 131071, -131072, 0, 131071, 131071, 0, 48'hFFFF_FFFE_0001, 2);

        // Reset held for 3 cycles
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_opmode", 64'(dsp_opmode), 64'h08);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_count", 64'(m_count), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 3; i++) begin
                va[i] = tbl[r].a[i];
                vb[i] = tbl[r].b[i];
            end
            send_vec(int'(tbl[r].n), int'(tbl[r].gap), int'(tbl[r].stall), d, c);
            chk($sformatf("tbl%0d_data", r), 64'(d), 64'(tbl[r].exp_data));
            chk($sformatf("tbl%0d_count", r), 64'(c), 64'(tbl[r].exp_count));
        end

        // Count saturation: 17 beats of 1*1
        for (int i = 0; i < 17; i++) begin
            va[i] = 18'sd1;
            vb[i] = 18'sd1;
        end
        send_vec(17, 0, 0, d, c);
        chk("sat_data", 64'(d), 64'd17);
        chk("sat_count", 64'(c), 64'd15);

        // Reset after two beats of 9*9, then a fresh single-beat vector
        s_valid = 1'b1; s_a = 18'd9; s_b = 18'd9; s_last = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        s_valid = 1'b0;
        RST_N   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_opmode", 64'(dsp_opmode), 64'h08);
        chk("midrst_s_ready", 64'(s_ready), 64'd1);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        va[0] = 18'sd4;
        vb[0] = 18'sd4;
        send_vec(1, 0, 0, d, c);
        chk("midrst_data", 64'(d), 64'd16);
        chk("midrst_count", 64'(c), 64'd1);

        // Randomized vectors against the arithmetic model
        for (int v = 0; v < 30; v++) begin
            int n;
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) begin
                va[i] = 18'($urandom);
                vb[i] = 18'($urandom);
            end
            send_vec(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), d, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
